// File: rtl/apu_sq1_write_scheduler.sv
// apu_sq1_write_scheduler
// Sole writer of the square-1 APU register bank. Host register writes arrive
// as UART nibble-pair bytes, are queued in a small FIFO and share the register
// port with a built-in sound-effect sequencer that owns the port while bursting
// or muting.
// Optional build macro: APU_SQ1_HOST_MASK_EN -- when defined, host writes that
// leave the queue while an effect is holding are discarded so the effect's
// registers stay untouched.
module apu_sq1_write_scheduler #(
    parameter int         FIFO_DEPTH = 2,
    parameter logic [7:0] MUTE_VAL   = 8'h30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       frame_tick,
    input  logic       sfx_req,
    input  logic [1:0] sfx_id,
    output logic       reg_we,
    output logic [1:0] reg_addr,
    output logic [7:0] reg_data,
    output logic       sfx_busy,
    output logic       host_err
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, BURST, HOLD, MUTE} state_t;

    // Burst write order is reg1, reg0, reg2, reg3.
    function automatic logic [1:0] burst_addr(input logic [1:0] step);
        case (step)
            2'd0:    burst_addr = 2'd1;
            2'd1:    burst_addr = 2'd0;
            default: burst_addr = step;
        endcase
    endfunction

    function automatic logic [7:0] burst_data(input logic [1:0] id, input logic [1:0] step);
        logic [31:0] row;
        case (id)
            2'd0:    row = 32'hA7_82_7C_09;
            2'd1:    row = 32'h93_9E_3A_0A;
            2'd2:    row = 32'hCB_9F_EF_08;
            default: row = 32'h00_00_00_00;
        endcase
        case (step)
            2'd0:    burst_data = row[31:24];
            2'd1:    burst_data = row[23:16];
            2'd2:    burst_data = row[15:8];
            default: burst_data = row[7:0];
        endcase
    endfunction

    function automatic logic [7:0] sfx_len(input logic [1:0] id);
        case (id)
            2'd0:    sfx_len = 8'h28;
            2'd1:    sfx_len = 8'h0A;
            2'd2:    sfx_len = 8'h0E;
            default: sfx_len = 8'h01;
        endcase
    endfunction

    state_t      state;
    logic [1:0]  idx;
    logic [1:0]  cur_id;
    logic [7:0]  cnt;
    logic        pend_valid;
    logic [1:0]  pend_id;
    logic [1:0]  next_id;
    logic        sfx_write;

    logic        lo_valid;
    logic [1:0]  lo_addr;
    logic [3:0]  lo_nib;

    logic [9:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] fifo_cnt;
    logic        fifo_empty;
    logic        fifo_full;

    logic        byte_bad;
    logic        is_lo;
    logic        is_hi;
    logic        pair_ok;
    logic        pair_bad;
    logic [9:0]  push_word;
    logic        host_go;
    logic        pop;
    logic        bypass;
    logic        do_push;
    logic        overflow;
    logic [9:0]  host_word;
    logic        host_emit;

    // Decide whether the sequencer drives the register port at the coming edge.
    always_comb begin
        sfx_write = 1'b0;
        next_id   = sfx_req ? sfx_id : pend_id;
        case (state)
            IDLE, HOLD: sfx_write = sfx_req && (sfx_id != 2'd3);
            BURST:      sfx_write = 1'b1;
            MUTE:       sfx_write = 1'b1;
            default:    sfx_write = 1'b0;
        endcase
    end

    // Decode host bytes and pick the host write source (queue head, or the
    // incoming pair directly when the queue is empty so latency stays one cycle).
    always_comb begin
        byte_bad   = rx_valid && rx_data[7];
        is_lo      = rx_valid && !rx_data[7] && !rx_data[4];
        is_hi      = rx_valid && !rx_data[7] && rx_data[4];
        pair_ok    = is_hi && lo_valid && (lo_addr == rx_data[6:5]);
        pair_bad   = is_hi && !pair_ok;
        push_word  = {rx_data[6:5], rx_data[3:0], lo_nib};
        fifo_cnt   = wr_ptr - rd_ptr;
        fifo_empty = (fifo_cnt == '0);
        fifo_full  = (fifo_cnt == FULL_CNT);
        host_go    = !sfx_write && ((state == IDLE) || (state == HOLD));
        pop        = host_go && !fifo_empty;
        bypass     = host_go && fifo_empty && pair_ok;
        do_push    = pair_ok && !bypass && (!fifo_full || pop);
        overflow   = pair_ok && !bypass && fifo_full && !pop;
        host_word  = fifo_empty ? push_word : fifo_mem[rd_ptr[AW-1:0]];
`ifdef APU_SQ1_HOST_MASK_EN
        host_emit  = (pop || bypass) && (state != HOLD);
`else
        host_emit  = pop || bypass;
`endif
    end

    // Host nibble latch and the error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_valid <= 1'b0;
            lo_addr  <= 2'd0;
            lo_nib   <= 4'd0;
            host_err <= 1'b0;
        end else begin
            if (is_lo) begin
                lo_valid <= 1'b1;
                lo_addr  <= rx_data[6:5];
                lo_nib   <= rx_data[3:0];
            end else if (is_hi) begin
                lo_valid <= 1'b0;
            end
            host_err <= byte_bad || pair_bad || overflow;
        end
    end

    // Host write queue pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Host write queue storage; contents are only meaningful between pointers.
    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr[AW-1:0]] <= push_word;
    end

    // Effect sequencer plus the registered register-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            cur_id     <= 2'd0;
            cnt        <= 8'd0;
            pend_valid <= 1'b0;
            pend_id    <= 2'd0;
            reg_we     <= 1'b0;
            reg_addr   <= 2'd0;
            reg_data   <= 8'd0;
            sfx_busy   <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    if (sfx_req) begin
                        sfx_busy   <= 1'b1;
                        cur_id     <= sfx_id;
                        pend_valid <= 1'b0;
                        if (sfx_id == 2'd3) begin
                            state <= MUTE;
                        end else begin
                            reg_we   <= 1'b1;
                            reg_addr <= burst_addr(2'd0);
                            reg_data <= burst_data(sfx_id, 2'd0);
                            idx      <= 2'd1;
                            state    <= BURST;
                        end
                    end else if (state == HOLD && frame_tick) begin
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd1) state <= MUTE;
                    end
                end
                BURST: begin
                    reg_we   <= 1'b1;
                    reg_addr <= burst_addr(idx);
                    reg_data <= burst_data(cur_id, idx);
                    if (idx == 2'd3) begin
                        if (sfx_req || pend_valid) begin
                            cur_id     <= next_id;
                            pend_valid <= 1'b0;
                            idx        <= 2'd0;
                            state      <= (next_id == 2'd3) ? MUTE : BURST;
                        end else begin
                            cnt   <= sfx_len(cur_id);
                            state <= HOLD;
                        end
                    end else begin
                        idx <= idx + 2'd1;
                        if (sfx_req) begin
                            pend_valid <= 1'b1;
                            pend_id    <= sfx_id;
                        end
                    end
                end
                MUTE: begin
                    reg_we <= 1'b1;
                    if (sfx_req && sfx_id != 2'd3) begin
                        cur_id   <= sfx_id;
                        reg_addr <= burst_addr(2'd0);
                        reg_data <= burst_data(sfx_id, 2'd0);
                        idx      <= 2'd1;
                        state    <= BURST;
                    end else begin
                        reg_addr <= 2'd0;
                        reg_data <= MUTE_VAL;
                        sfx_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (host_emit) begin
                reg_we   <= 1'b1;
                reg_addr <= host_word[9:8];
                reg_data <= host_word[7:0];
            end
        end
    end

endmodule
